// File: rtl/power_activity_monitor.sv
// Activity monitor for a gated compute domain: drops activity after a quiet
// window, tracks the power manager's clock-enable, and sequences wake-up.
module power_activity_monitor #(
    parameter int IDLE_CYCLES = 64,
    parameter int WAKE_CYCLES = 4,
    parameter int SLEEP_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    input  logic                   busy_i,
    input  logic                   clk_en_i,
    output logic                   req_ready_o,
    output logic                   activity_o,
    output logic                   wake_pending_o,
    output logic [2:0]             state_o,
    output logic [SLEEP_CNT_W-1:0] sleep_cnt_o
);

    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int WW = $clog2(WAKE_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

    localparam logic [2:0] ST_ACTIVE    = 3'd0;
    localparam logic [2:0] ST_COUNTDOWN = 3'd1;
    localparam logic [2:0] ST_SLEEP_REQ = 3'd2;
    localparam logic [2:0] ST_SLEEP     = 3'd3;
    localparam logic [2:0] ST_WAKE      = 3'd4;

    // Request handshake: a request transfers on a cycle where req_valid_i and
    // req_ready_o are both high; ready never depends on valid.
    logic [2:0]    state_q, state_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [WW-1:0] wake_q, wake_d;
    logic          sleep_inc;
    logic          activity_d, wake_pending_d;
    logic          quiet;

    assign quiet = !req_valid_i && !busy_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_ACTIVE;
            idle_q         <= '0;
            wake_q         <= '0;
            activity_o     <= 1'b1;
            wake_pending_o <= 1'b0;
            sleep_cnt_o    <= '0;
        end else begin
            state_q        <= state_d;
            idle_q         <= idle_d;
            wake_q         <= wake_d;
            activity_o     <= activity_d;
            wake_pending_o <= wake_pending_d;
            if (sleep_inc && (sleep_cnt_o != '1)) begin
                sleep_cnt_o <= sleep_cnt_o + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idle_d    = idle_q;
        wake_d    = wake_q;
        sleep_inc = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                idle_d = '0;
                if (quiet) begin
                    state_d = ST_COUNTDOWN;
                    idle_d  = IW'(1);
                end
            end
            ST_COUNTDOWN: begin
                if (!quiet) begin
                    state_d = ST_ACTIVE;
                    idle_d  = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d = ST_SLEEP_REQ;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            ST_SLEEP_REQ: begin
                idle_d = '0;
                // Abort only while the clock still runs; once it is off a
                // request has to go through the wake sequence.
                if ((req_valid_i || busy_i) && clk_en_i) begin
                    state_d = ST_ACTIVE;
                end else if (req_valid_i) begin
                    state_d = ST_WAKE;
                end else if (!clk_en_i) begin
                    state_d   = ST_SLEEP;
                    sleep_inc = 1'b1;
                end
            end
            ST_SLEEP: begin
                if (req_valid_i) begin
                    state_d = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (!clk_en_i) begin
                    wake_d = '0;
                end else if (wake_q == WAKE_LAST) begin
                    state_d = ST_ACTIVE;
                    wake_d  = '0;
                end else begin
                    wake_d = wake_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
                idle_d  = '0;
                wake_d  = '0;
            end
        endcase
    end

    // Registered flags follow the state being entered on this edge.
    always_comb begin
        activity_d     = (state_d == ST_ACTIVE) || (state_d == ST_COUNTDOWN) ||
                         (state_d == ST_WAKE);
        wake_pending_d = (state_d == ST_WAKE);
    end

    assign req_ready_o = clk_en_i && ((state_q == ST_ACTIVE) || (state_q == ST_COUNTDOWN));
    assign state_o     = state_q;

endmodule

// File: tb/tb_power_activity_monitor.sv
// Directed bench for power_activity_monitor (IDLE_CYCLES=8, WAKE_CYCLES=2,
// 2-bit sleep counter so saturation is reachable).
module tb_power_activity_monitor;

    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid_i;
    logic          busy_i;
    logic          clk_en_i;
    logic          req_ready_o;
    logic          activity_o;
    logic          wake_pending_o;
    logic [2:0]    state_o;
    logic [SW-1:0] sleep_cnt_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       req;
        logic       busy;
        logic       en;
        logic [2:0] st;
        logic       act;
        logic       wp;
        logic       rdy;
        int         sc;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    power_activity_monitor #(
        .IDLE_CYCLES(8),
        .WAKE_CYCLES(2),
        .SLEEP_CNT_W(SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .busy_i        (busy_i),
        .clk_en_i      (clk_en_i),
        .req_ready_o   (req_ready_o),
        .activity_o    (activity_o),
        .wake_pending_o(wake_pending_o),
        .state_o       (state_o),
        .sleep_cnt_o   (sleep_cnt_o)
    );

    task automatic chk(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Power-manager model: clk_en_i is activity_o delayed by one register.
    task automatic step_pm();
        logic saved;
        saved = activity_o;
        @(posedge clk);
        #1;
        clk_en_i = saved;
    endtask

    task automatic add_vec(input logic req, input logic busy, input logic en,
                           input logic [2:0] st, input logic act, input logic wp,
                           input logic rdy, input int sc);
        vec_t v;
        v.req = req; v.busy = busy; v.en = en; v.st = st;
        v.act = act; v.wp = wp; v.rdy = rdy; v.sc = sc;
        vecs.push_back(v);
    endtask

    // From ACTIVE with the clock running: idle into SLEEP, then wake again.
    task automatic sleep_wake(input int exp_sc);
        int n;
        req_valid_i = 1'b0;
        busy_i      = 1'b0;
        n = 0;
        while (state_o != 3'd3 && n < 40) begin
            step_pm();
            n++;
        end
        chk("reach_sleep", int'(state_o), 3);
        chk("sleep_cnt_sat", int'(sleep_cnt_o), exp_sc);
        req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        clk_en_i    = 1'b1;
        step();
        step();
        chk("rewake_state", int'(state_o), 0);
    endtask

    initial begin
        rst         = 1'b1;
        req_valid_i = 1'b0;
        busy_i      = 1'b0;
        clk_en_i    = 1'b1;
        repeat (3) step();
        chk("rst_state", int'(state_o), 0);
        chk("rst_activity", int'(activity_o), 1);
        chk("rst_sleep_cnt", int'(sleep_cnt_o), 0);
        chk("rst_wake_pending", int'(wake_pending_o), 0);
        chk("rst_ready", int'(req_ready_o), 1);
        rst = 1'b0;

        // Idle to sleep: SLEEP_REQ on the 8th edge after the first quiet cycle.
        for (int i = 1; i <= 8; i++) begin
            step_pm();
            chk($sformatf("idle_state_%0d", i), int'(state_o), (i < 8) ? 1 : 2);
        end
        chk("sreq_activity", int'(activity_o), 0);
        chk("sreq_ready", int'(req_ready_o), 0);
        step_pm();
        chk("sreq_hold_state", int'(state_o), 2);
        chk("sreq_clk_en_low", int'(clk_en_i), 0);
        step_pm();
        chk("sleep_state", int'(state_o), 3);
        chk("sleep_cnt_1", int'(sleep_cnt_o), 1);
        chk("sleep_ready", int'(req_ready_o), 0);
        busy_i = 1'b1;
        step();
        chk("sleep_ignores_busy", int'(state_o), 3);
        busy_i = 1'b0;

        // Wake with broken enable, then re-idle and hit the simultaneous event.
        add_vec(1, 0, 0, 3'd4, 1, 1, 0, 1);
        add_vec(0, 0, 1, 3'd4, 1, 1, 0, 1);
        add_vec(0, 0, 0, 3'd4, 1, 1, 0, 1);
        add_vec(0, 0, 1, 3'd4, 1, 1, 0, 1);
        add_vec(0, 0, 1, 3'd0, 1, 0, 1, 1);
        for (int i = 1; i <= 8; i++) begin
            add_vec(0, 0, 1, (i < 8) ? 3'd1 : 3'd2, (i < 8) ? 1'b1 : 1'b0, 0,
                    (i < 8) ? 1'b1 : 1'b0, 1);
        end
        add_vec(1, 0, 0, 3'd4, 1, 1, 0, 1);
        add_vec(0, 0, 1, 3'd4, 1, 1, 0, 1);
        add_vec(0, 0, 1, 3'd0, 1, 0, 1, 1);
        foreach (vecs[i]) begin
            req_valid_i = vecs[i].req;
            busy_i      = vecs[i].busy;
            clk_en_i    = vecs[i].en;
            step();
            chk($sformatf("vec%0d_state", i), int'(state_o), int'(vecs[i].st));
            chk($sformatf("vec%0d_activity", i), int'(activity_o), int'(vecs[i].act));
            chk($sformatf("vec%0d_wake_pending", i), int'(wake_pending_o), int'(vecs[i].wp));
            chk($sformatf("vec%0d_ready", i), int'(req_ready_o), int'(vecs[i].rdy));
            chk($sformatf("vec%0d_sleep_cnt", i), int'(sleep_cnt_o), vecs[i].sc);
        end

        // Countdown abort: 5 quiet, 1 busy, then a full fresh 8-cycle window.
        req_valid_i = 1'b0;
        busy_i      = 1'b0;
        clk_en_i    = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("abort_quiet_%0d", i), int'(state_o), 1);
        end
        busy_i = 1'b1;
        step();
        chk("abort_to_active", int'(state_o), 0);
        busy_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("abort_window_%0d", i), int'(state_o), (i < 8) ? 1 : 2);
        end

        // SLEEP_REQ abort while the clock is still enabled.
        busy_i = 1'b1;
        step();
        chk("sreq_abort_state", int'(state_o), 0);
        chk("sreq_abort_activity", int'(activity_o), 1);
        busy_i = 1'b0;

        // Saturation: four more sleeps bring the total to five.
        sleep_wake(2);
        sleep_wake(3);
        sleep_wake(3);
        sleep_wake(3);

        // Reset while in WAKE.
        req_valid_i = 1'b0;
        busy_i      = 1'b0;
        for (int i = 0; i < 40 && state_o != 3'd3; i++) step_pm();
        req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        chk("pre_rst_wake", int'(state_o), 4);
        rst = 1'b1;
        step();
        chk("rst_wake_state", int'(state_o), 0);
        chk("rst_wake_activity", int'(activity_o), 1);
        chk("rst_wake_sleep_cnt", int'(sleep_cnt_o), 0);
        chk("rst_wake_pending", int'(wake_pending_o), 0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/power_activity_monitor.md
Name: power_activity_monitor

Overview:
- Produces the activity indication and consumes the registered clock-enable of the block-level clock-gating manager.
- Watches request traffic and the domain busy flag, then asks for clock-off after a programmable quiet period.
- Blocks new requests while the clock is off or settling, and sequences wake-up when traffic returns.
- Sits between the upstream request source and the gated compute domain.

Parameters:
IDLE_CYCLES, 64, consecutive quiet cycles before sleep is requested; legal range >= 2
WAKE_CYCLES, 4, consecutive cycles with clk_en_i=1 before requests are accepted again; legal range >= 1
SLEEP_CNT_W, 16, width of the saturating sleep-entry counter

Ports:
clk  input  1  single clock for the block
rst  input  1  synchronous reset, active-high
req_valid_i  input  1  upstream has a request pending
busy_i  input  1  gated domain has in-flight work
clk_en_i  input  1  registered clock-enable returned by the power manager
req_ready_o  output  1  request may be accepted this cycle
activity_o  output  1  registered activity flag, drives the power manager activity input
wake_pending_o  output  1  registered; high in WAKE
state_o  output  3  current FSM state encoding
sleep_cnt_o  output  SLEEP_CNT_W  number of SLEEP entries, saturating

Behaviour:
- Reset is synchronous, active-high, and is sampled only on the clk rising edge.
- Reset values:
  - state = ACTIVE (3'd0)
  - activity_o = 1, so the domain is clocked out of reset
  - wake_pending_o = 0, sleep_cnt_o = 0
  - idle_cnt = 0, wake_cnt = 0
- Reset mid-sequence, in any state, forces these values on the next edge.
- req_ready_o is combinational: req_ready_o = clk_en_i & (state==ACTIVE | state==COUNTDOWN).
- "quiet" means !req_valid_i & !busy_i.
- State encoding: ACTIVE=0, COUNTDOWN=1, SLEEP_REQ=2, SLEEP=3, WAKE=4. Codes 5-7 are illegal and recover to ACTIVE on the next edge.
- ACTIVE:
  - activity_o=1.
  - quiet -> COUNTDOWN with idle_cnt=1; otherwise stay.
- COUNTDOWN:
  - not quiet -> ACTIVE, idle_cnt=0.
  - quiet and idle_cnt==IDLE_CYCLES-1 -> SLEEP_REQ.
  - otherwise idle_cnt++.
  - SLEEP_REQ is entered on the edge ending the IDLE_CYCLES-th consecutive quiet cycle.
- SLEEP_REQ:
  - activity_o=0 from the entry edge.
  - Priority order:
    1. req_valid_i | busy_i with clk_en_i=1 -> ACTIVE, activity_o=1 (abort).
    2. req_valid_i with clk_en_i=0 -> WAKE (request wins over sleep; clock is already off).
    3. clk_en_i=0 -> SLEEP, sleep_cnt_o++ (saturating at all-ones).
    4. otherwise stay.
- SLEEP:
  - activity_o=0, req_ready_o=0.
  - req_valid_i -> WAKE with activity_o=1 and wake_pending_o=1.
  - busy_i is ignored in SLEEP.
- WAKE:
  - activity_o=1, wake_pending_o=1.
  - Each cycle with clk_en_i=1 increments wake_cnt. Any cycle with clk_en_i=0 clears wake_cnt to 0.
  - wake_cnt==WAKE_CYCLES-1 with clk_en_i=1 -> ACTIVE, wake_cnt=0, wake_pending_o=0.
  - Requests are not accepted in WAKE.
- Round-trip latency: the power manager adds one register stage.
  - After activity_o falls, clk_en_i falls at the earliest one cycle later.
  - SLEEP entry is therefore at least 2 cycles after the end of COUNTDOWN.
- Counters:
  - idle_cnt is $clog2(IDLE_CYCLES+1) bits wide, wake_cnt is $clog2(WAKE_CYCLES+1) bits wide.
  - Both are cleared on every state exit and never wrap.
- An external enable held low also leads to SLEEP: SLEEP_REQ waits indefinitely, and the abort path is available only while clk_en_i=1.

Test Plan:
- Reset check (IDLE_CYCLES=8, WAKE_CYCLES=2): hold rst=1 for 3 cycles -> state_o=0, activity_o=1, sleep_cnt_o=0, wake_pending_o=0; with clk_en_i=1, req_ready_o=1.
- Idle to sleep: all inputs quiet, clk_en_i follows activity_o with 1-cycle delay.
  - Required: state_o=2 exactly 8 edges after the first quiet cycle.
  - Required: activity_o=0 at that edge; state_o=3 one edge after clk_en_i falls; sleep_cnt_o=1.
- Countdown abort: quiet for 5 cycles, then busy_i=1 for 1 cycle -> state_o returns to 0, idle_cnt=0; a new full 8-cycle quiet window is needed before state_o=2.
- Wake sequence: in SLEEP, pulse req_valid_i -> next edge state_o=4, activity_o=1, wake_pending_o=1.
  - Drive clk_en_i=1,0,1,1 -> state_o=0 only after the second consecutive 1.
  - req_ready_o stays 0 until then.
- Simultaneous event: in SLEEP_REQ, assert req_valid_i on the same cycle clk_en_i falls -> state_o=4, not 3; sleep_cnt_o unchanged.
- Saturation and reset: SLEEP_CNT_W=2, complete 5 sleep/wake cycles -> sleep_cnt_o=3; assert rst in WAKE -> next edge state_o=0, activity_o=1, sleep_cnt_o=0.
